// File: rtl/sysref_period_monitor_if.sv
// Bus between the SYSREF capture stage, the period monitor, and its consumers.
// The master side drives the SYSREF level and the controls.
// The slave side (the monitor) returns the strobes and the lock/period status.
interface sysref_period_monitor_if #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic             sysref_adc;
    logic             enable;
    logic             clear_status;
    logic             sysref_pulse;
    logic             sysref_aligned;
    logic             locked;
    logic [CNT_W-1:0] ref_period;
    logic [CNT_W-1:0] last_period;
    logic             lock_lost;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       state_dbg;

    modport master (
        output sysref_adc, enable, clear_status,
        input  sysref_pulse, sysref_aligned, locked, ref_period, last_period,
               lock_lost, err_count, state_dbg
    );

    modport slave (
        input  sysref_adc, enable, clear_status,
        output sysref_pulse, sysref_aligned, locked, ref_period, last_period,
               lock_lost, err_count, state_dbg
    );
endinterface

// File: rtl/sysref_period_monitor.sv
// SYSREF period monitor. It detects rising edges of the captured SYSREF level
// and measures the spacing between them in pl_clk cycles. After enough
// consecutive in-tolerance periods it declares lock, and from then on it
// emits an aligned strobe for each good edge. It records mismatches and
// missing edges in sticky and saturating status registers.
module sysref_period_monitor #(
    parameter int CNT_W      = 16,
    parameter int MAX_PERIOD = 4096,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1,
    parameter int ERR_W      = 8
) (
    input logic                     pl_clk,
    input logic                     rst,
    sysref_period_monitor_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        MEASURE = 3'd2,
        VERIFY  = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(MAX_PERIOD);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state, state_next;
    logic             s_d;
    logic             rise;
    logic             en;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   abs_diff;
    logic             match;
    logic [MC_W-1:0]  match_cnt;
    logic             verify_done;

    logic             load_ref;
    logic             inc_match;
    logic             upd_last;
    logic             aligned_evt;
    logic             err_evt;

    logic             pulse_q;
    logic             aligned_q;
    logic             locked_q;
    logic [CNT_W-1:0] ref_q;
    logic [CNT_W-1:0] last_q;
    logic             lost_q;
    logic [ERR_W-1:0] err_q;

    assign en          = bus.enable;
    assign rise        = bus.sysref_adc & ~s_d;
    assign timeout     = (cnt == TO_CNT) && !rise;
    // The extra bit keeps a short period from wrapping around and looking like a match.
    assign diff        = {1'b0, cnt} - {1'b0, ref_q};
    assign abs_diff    = diff[CNT_W] ? -diff : diff;
    assign match       = abs_diff <= (CNT_W+1)'(TOL);
    assign verify_done = (int'(match_cnt) + 1) >= (LOCK_COUNT - 1);

    // Edge history and period counter; the counter restarts at 1 on every rise.
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            s_d <= 1'b0;
            cnt <= '0;
        end else begin
            s_d <= bus.sysref_adc;
            if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: a disable always wins, and any failure falls back to ACQUIRE.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ACQUIRE;
                ACQUIRE: if (rise) state_next = MEASURE;
                MEASURE: begin
                    if (rise)
                        state_next = (LOCK_COUNT > 1) ? VERIFY : LOCKED;
                    else if (timeout)
                        state_next = ACQUIRE;
                end
                VERIFY: begin
                    if (rise && match && verify_done)
                        state_next = LOCKED;
                    else if (timeout)
                        state_next = ACQUIRE;
                end
                LOCKED: begin
                    if ((rise && !match) || timeout)
                        state_next = ACQUIRE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Decode per-cycle datapath actions from the current state and edge events.
    always_comb begin
        load_ref    = 1'b0;
        inc_match   = 1'b0;
        upd_last    = 1'b0;
        aligned_evt = 1'b0;
        err_evt     = 1'b0;
        if (en) begin
            case (state)
                MEASURE: begin
                    load_ref = rise;
                    upd_last = rise;
                end
                VERIFY: begin
                    load_ref  = rise && !match;
                    inc_match = rise && match;
                    upd_last  = rise;
                end
                LOCKED: begin
                    upd_last    = rise;
                    aligned_evt = rise && match;
                    err_evt     = (rise && !match) || timeout;
                end
                default: ;
            endcase
        end
    end

    // Registered strobes, match tracking and period capture.
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            pulse_q   <= 1'b0;
            aligned_q <= 1'b0;
            locked_q  <= 1'b0;
            match_cnt <= '0;
            ref_q     <= '0;
            last_q    <= '0;
        end else begin
            pulse_q   <= en && rise;
            aligned_q <= aligned_evt;
            locked_q  <= (state_next == LOCKED);
            if (!en || load_ref)
                match_cnt <= '0;
            else if (inc_match)
                match_cnt <= match_cnt + MC_W'(1);
            if (load_ref)
                ref_q <= cnt;
            if (upd_last)
                last_q <= cnt;
        end
    end

    // Sticky loss flag and saturating error count; a new error beats a clear in the same cycle.
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            lost_q <= 1'b0;
            err_q  <= '0;
        end else if (err_evt) begin
            lost_q <= 1'b1;
            if (bus.clear_status)
                err_q <= ERR_W'(1);
            else if (err_q != ERR_MAX)
                err_q <= err_q + ERR_W'(1);
        end else if (bus.clear_status) begin
            lost_q <= 1'b0;
            err_q  <= '0;
        end
    end

    assign bus.sysref_pulse   = pulse_q;
    assign bus.sysref_aligned = aligned_q;
    assign bus.locked         = locked_q;
    assign bus.ref_period     = ref_q;
    assign bus.last_period    = last_q;
    assign bus.lock_lost      = lost_q;
    assign bus.err_count      = err_q;
    assign bus.state_dbg      = state;

endmodule

// File: tb/tb_sysref_period_monitor.sv
// Directed testbench for sysref_period_monitor. It runs with the default
// parameters (MAX_PERIOD 4096, LOCK_COUNT 4, TOL 1).
module tb_sysref_period_monitor;

    logic pl_clk = 1'b0;
    logic rst    = 1'b1;

    int tests_run = 0;
    int failures  = 0;

    int pulse_seen;
    int aligned_seen;
    int pulse_first;
    int aligned_first;

    sysref_period_monitor_if #(.CNT_W(16), .ERR_W(8)) bus ();

    sysref_period_monitor dut (
        .pl_clk (pl_clk),
        .rst    (rst),
        .bus    (bus)
    );

    // Free-running 100 MHz pl_clk.
    always #5 pl_clk = ~pl_clk;

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic apply_reset();
        rst              = 1'b1;
        bus.sysref_adc   = 1'b0;
        bus.enable       = 1'b0;
        bus.clear_status = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One SYSREF edge followed by a window of `period` cycles (high for 4 cycles).
    // It records where the pulse and the aligned strobe appear in the window.
    task automatic send_edge(input int period);
        pulse_seen    = 0;
        aligned_seen  = 0;
        pulse_first   = -1;
        aligned_first = -1;
        bus.sysref_adc = 1'b1;
        for (int i = 0; i < period; i++) begin
            if (i == 4) bus.sysref_adc = 1'b0;
            tick();
            if (bus.sysref_pulse === 1'b1) begin
                pulse_seen++;
                if (pulse_first < 0) pulse_first = i;
            end
            if (bus.sysref_aligned === 1'b1) begin
                aligned_seen++;
                if (aligned_first < 0) aligned_first = i;
            end
        end
    endtask

    task automatic do_lock();
        apply_reset();
        bus.enable = 1'b1;
        tick();
        repeat (5) send_edge(32);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (bus.state_dbg !== 3'd0 || bus.locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: got state=%0d locked=%0d, expected 0/0", bus.state_dbg, bus.locked);
        end
        tests_run++;
        if (bus.ref_period !== 16'd0 || bus.last_period !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_periods: got ref=%0d last=%0d, expected 0/0", bus.ref_period, bus.last_period);
        end
        tests_run++;
        if (bus.lock_lost !== 1'b0 || bus.err_count !== 8'd0 || bus.sysref_pulse !== 1'b0 || bus.sysref_aligned !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status: got lost=%0d err=%0d pulse=%0d aligned=%0d, expected all 0",
                     bus.lock_lost, bus.err_count, bus.sysref_pulse, bus.sysref_aligned);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        bus.enable = 1'b1;
        tick();
        tests_run++;
        if (bus.state_dbg !== 3'd1) begin
            failures++;
            $display("[TB] FAIL lock_enter_acquire: got state=%0d, expected 1", bus.state_dbg);
        end
        send_edge(32);
        tests_run++;
        if (pulse_seen != 1 || pulse_first != 0 || bus.state_dbg !== 3'd2) begin
            failures++;
            $display("[TB] FAIL lock_first_edge: got pulses=%0d at %0d state=%0d, expected 1 at 0 state 2",
                     pulse_seen, pulse_first, bus.state_dbg);
        end
        send_edge(32);
        tests_run++;
        if (bus.ref_period !== 16'd32 || bus.state_dbg !== 3'd3) begin
            failures++;
            $display("[TB] FAIL lock_ref_latch: got ref=%0d state=%0d, expected 32 state 3", bus.ref_period, bus.state_dbg);
        end
        send_edge(32);
        send_edge(32);
        tests_run++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lock_not_early: got locked=%0d after 4 edges, expected 0", bus.locked);
        end
        send_edge(32);
        tests_run++;
        if (bus.locked !== 1'b1 || bus.state_dbg !== 3'd4 || aligned_seen != 0) begin
            failures++;
            $display("[TB] FAIL lock_fifth_edge: got locked=%0d state=%0d aligned=%0d, expected 1/4/0",
                     bus.locked, bus.state_dbg, aligned_seen);
        end
        for (int e = 0; e < 3; e++) begin
            send_edge(32);
            tests_run++;
            if (aligned_seen != 1 || aligned_first != 0 || pulse_first != 0) begin
                failures++;
                $display("[TB] FAIL lock_aligned_edge%0d: got aligned=%0d at %0d pulse at %0d, expected 1 at 0 / 0",
                         e, aligned_seen, aligned_first, pulse_first);
            end
        end
        tests_run++;
        if (bus.err_count !== 8'd0 || bus.last_period !== 16'd32) begin
            failures++;
            $display("[TB] FAIL lock_status: got err=%0d last=%0d, expected 0/32", bus.err_count, bus.last_period);
        end
    endtask

    task automatic test_drift();
        do_lock();
        send_edge(34);
        tests_run++;
        if (aligned_seen != 1) begin
            failures++;
            $display("[TB] FAIL drift_pre_edge: got aligned=%0d, expected 1", aligned_seen);
        end
        send_edge(32);
        tests_run++;
        if (aligned_seen != 0 || pulse_seen != 1 || bus.locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drift_edge: got aligned=%0d pulse=%0d locked=%0d, expected 0/1/0",
                     aligned_seen, pulse_seen, bus.locked);
        end
        tests_run++;
        if (bus.lock_lost !== 1'b1 || bus.err_count !== 8'd1 || bus.state_dbg !== 3'd1) begin
            failures++;
            $display("[TB] FAIL drift_status: got lost=%0d err=%0d state=%0d, expected 1/1/1",
                     bus.lock_lost, bus.err_count, bus.state_dbg);
        end
        tests_run++;
        if (bus.ref_period !== 16'd32 || bus.last_period !== 16'd34) begin
            failures++;
            $display("[TB] FAIL drift_periods: got ref=%0d last=%0d, expected 32/34", bus.ref_period, bus.last_period);
        end
        repeat (4) send_edge(32);
        tests_run++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drift_relock_early: got locked=%0d after 4 edges, expected 0", bus.locked);
        end
        send_edge(32);
        tests_run++;
        if (bus.locked !== 1'b1 || bus.ref_period !== 16'd32 || bus.err_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL drift_relock: got locked=%0d ref=%0d err=%0d, expected 1/32/1",
                     bus.locked, bus.ref_period, bus.err_count);
        end
    endtask

    task automatic test_tolerance();
        do_lock();
        send_edge(33);
        send_edge(32);
        tests_run++;
        if (aligned_seen != 1 || bus.locked !== 1'b1 || bus.last_period !== 16'd33) begin
            failures++;
            $display("[TB] FAIL tol_33: got aligned=%0d locked=%0d last=%0d, expected 1/1/33",
                     aligned_seen, bus.locked, bus.last_period);
        end
        send_edge(31);
        send_edge(32);
        tests_run++;
        if (aligned_seen != 1 || bus.ref_period !== 16'd32 || bus.last_period !== 16'd31 || bus.err_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL tol_31: got aligned=%0d ref=%0d last=%0d err=%0d, expected 1/32/31/0",
                     aligned_seen, bus.ref_period, bus.last_period, bus.err_count);
        end
        send_edge(30);
        send_edge(32);
        tests_run++;
        if (aligned_seen != 0 || bus.locked !== 1'b0 || bus.err_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL tol_30: got aligned=%0d locked=%0d err=%0d, expected 0/0/1",
                     aligned_seen, bus.locked, bus.err_count);
        end
    endtask

    task automatic test_timeout();
        do_lock();
        repeat (4064) tick();
        tests_run++;
        if (bus.locked !== 1'b1 || bus.state_dbg !== 3'd4) begin
            failures++;
            $display("[TB] FAIL timeout_early: got locked=%0d state=%0d, expected 1/4", bus.locked, bus.state_dbg);
        end
        tick();
        tests_run++;
        if (bus.locked !== 1'b0 || bus.lock_lost !== 1'b1 || bus.err_count !== 8'd1 || bus.state_dbg !== 3'd1) begin
            failures++;
            $display("[TB] FAIL timeout_fire: got locked=%0d lost=%0d err=%0d state=%0d, expected 0/1/1/1",
                     bus.locked, bus.lock_lost, bus.err_count, bus.state_dbg);
        end
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
        tests_run++;
        if (bus.lock_lost !== 1'b0 || bus.err_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL timeout_clear: got lost=%0d err=%0d, expected 0/0", bus.lock_lost, bus.err_count);
        end
    endtask

    task automatic test_set_wins();
        do_lock();
        repeat (4064) tick();
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
        tests_run++;
        if (bus.lock_lost !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL set_wins: got lost=%0d err=%0d locked=%0d, expected 1/1/0",
                     bus.lock_lost, bus.err_count, bus.locked);
        end
    endtask

    task automatic test_held_high();
        int pulses;
        apply_reset();
        bus.enable = 1'b1;
        tick();
        pulses = 0;
        bus.sysref_adc = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (i == 100) bus.sysref_adc = 1'b0;
            tick();
            if (bus.sysref_pulse === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 1) begin
            failures++;
            $display("[TB] FAIL held_high: got %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic test_reset_midlock();
        do_lock();
        bus.sysref_adc = 1'b1;
        tick();
        tests_run++;
        if (bus.sysref_aligned !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midlock_pre: got aligned=%0d, expected 1", bus.sysref_aligned);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.sysref_aligned !== 1'b0 || bus.sysref_pulse !== 1'b0 || bus.locked !== 1'b0 || bus.state_dbg !== 3'd0) begin
            failures++;
            $display("[TB] FAIL midlock_async: got aligned=%0d pulse=%0d locked=%0d state=%0d, expected all 0",
                     bus.sysref_aligned, bus.sysref_pulse, bus.locked, bus.state_dbg);
        end
        tests_run++;
        if (bus.ref_period !== 16'd0 || bus.last_period !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midlock_periods: got ref=%0d last=%0d, expected 0/0", bus.ref_period, bus.last_period);
        end
        bus.sysref_adc = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_enable_drop();
        do_lock();
        bus.enable = 1'b0;
        tick();
        tests_run++;
        if (bus.state_dbg !== 3'd0 || bus.locked !== 1'b0 || bus.ref_period !== 16'd32) begin
            failures++;
            $display("[TB] FAIL enable_drop: got state=%0d locked=%0d ref=%0d, expected 0/0/32",
                     bus.state_dbg, bus.locked, bus.ref_period);
        end
        send_edge(32);
        tests_run++;
        if (pulse_seen != 0 || bus.last_period !== 16'd32 || bus.lock_lost !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_low_edge: got pulses=%0d last=%0d lost=%0d, expected 0/32/0",
                     pulse_seen, bus.last_period, bus.lock_lost);
        end
    endtask

    // Run every scenario in sequence and report.
    initial begin
        test_reset();
        test_lock();
        test_drift();
        test_tolerance();
        test_timeout();
        test_set_wins();
        test_held_high();
        test_reset_midlock();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/sysref_period_monitor.md
Name: sysref_period_monitor

Overview:
Downstream consumer of the registered PL SYSREF capture output (sysref_adc, sampled on pl_clk). Detects SYSREF rising edges and measures the SYSREF period in pl_clk cycles. Declares lock after a configurable number of consecutive matching periods and thereafter emits a one-cycle aligned strobe per edge. Feeds the multi-tile sync / PL-side timestamp logic and flags SYSREF loss or period drift to software.

Parameters:
CNT_W, 16, width of period counter and period outputs
MAX_PERIOD, 4096, cycles without an edge before missing-edge timeout; must be < 2^CNT_W
LOCK_COUNT, 4, consecutive in-tolerance periods required to assert lock (>= 1)
TOL, 1, allowed |measured - reference| deviation in cycles
ERR_W, 8, width of saturating error counter

Ports:
pl_clk  in  1  PL clock, same domain as sysref_adc
rst  in  1  asynchronous active-high reset
sysref_adc  in  1  registered SYSREF level from the capture stage
enable  in  1  monitor enable; low forces IDLE
clear_status  in  1  one-cycle pulse, clears lock_lost and err_count
sysref_pulse  out  1  one-cycle pulse per detected rising edge, unqualified
sysref_aligned  out  1  one-cycle pulse per in-tolerance edge while locked
locked  out  1  lock status
ref_period  out  CNT_W  reference period latched at acquisition
last_period  out  CNT_W  most recent measured period
lock_lost  out  1  sticky: locked fell due to mismatch or timeout
err_count  out  ERR_W  saturating count of mismatches plus timeouts
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (async assert, sync release on pl_clk): all outputs 0; FSM IDLE; internal s_d = 0, cnt = 0, match count = 0.
- Edge detect: s_d <= sysref_adc every cycle; rise = sysref_adc & ~s_d. Level held high for many cycles yields a single rise.
- sysref_pulse is registered: high exactly one cycle after the cycle in which rise is true. Asserted in all states, including IDLE, whenever enable = 1.
- Counter: on a rise cycle, cnt <= 1; otherwise cnt <= cnt + 1, saturating at 2^CNT_W - 1. On a rise cycle, measured period = cnt (edges N cycles apart give N). last_period <= measured on every rise except the first edge in ACQUIRE.
- Timeout: cnt == MAX_PERIOD with no rise is a missing-edge event.
- Match: |measured - ref_period| <= TOL, computed without wrap (use CNT_W+1 bit difference).
- FSM encodings: IDLE=0, ACQUIRE=1, MEASURE=2, VERIFY=3, LOCKED=4.
  IDLE: enable=1 -> ACQUIRE.
  ACQUIRE: on rise -> MEASURE; counter starts.
  MEASURE: on rise -> ref_period <= measured, match count <= 0, then VERIFY if LOCK_COUNT > 1, else LOCKED. Timeout -> ACQUIRE; no error counted.
  VERIFY: on rise with match -> match count + 1; when the count reaches LOCK_COUNT-1 -> LOCKED. Rise with mismatch -> ref_period <= measured, match count <= 0, stay in VERIFY. Timeout -> ACQUIRE. No errors counted before first lock.
  LOCKED: locked = 1 (registered, asserted the cycle after entry). On rise with match, sysref_aligned pulses with the same timing as sysref_pulse. Rise with mismatch or timeout -> err_count +1, lock_lost <= 1, locked <= 0, next state ACQUIRE; ref_period holds until the next acquisition.
- enable low in any state: next cycle FSM IDLE, locked 0, match count 0; ref_period, last_period, lock_lost and err_count hold.
- err_count saturates at 2^ERR_W - 1.
- clear_status and a new error in the same cycle: the set wins (lock_lost = 1, err_count = 1).
- Reset mid-lock: immediate return to reset values; no aligned pulse is emitted.

Test Plan:
- Periodic SYSREF, period 32, high 4 cycles, LOCK_COUNT=4 -> sysref_pulse 1 cycle after each rise; ref_period=32; locked asserts after the 5th edge; sysref_aligned on each subsequent edge; err_count=0.
- Locked at 32, one period of 34 (TOL=1) -> no aligned pulse on that edge; locked falls; lock_lost=1; err_count=1; relock with ref_period=32 after 5 further good edges.
- Period 33 while ref 32 -> still matched; aligned pulse; locked stays 1; last_period=33.
- Locked, SYSREF stops -> at cnt==4096 locked=0, lock_lost=1, err_count=1, state ACQUIRE; clear_status then -> lock_lost=0, err_count=0.
- sysref_adc held high 100 cycles then low -> exactly one sysref_pulse.
- Async rst asserted mid-cycle while locked -> all outputs 0 immediately. enable dropped while locked -> state IDLE, locked 0, ref_period held.
